aes_round_ctrl: RTL and testbench

Iterative AES encryption sequencer for a single shared registered round unit (SubBytes/ShiftRows/MixColumns/AddRoundKey, output registered on enable, MixColumns bypass selectable).
- Accepts a plaintext block over a valid/ready handshake and applies the initial AddRoundKey (whitening) itself.
- Drives the round unit for NR rounds, selecting each round key by index from an external round-key store and bypassing MixColumns on the final round.
- Presents the ciphertext over a valid/ready handshake.
- Sits between the block-level I/O and the round unit/key store in the encryption core.

---
 rtl/aes_round_ctrl.sv | 89 ++++++++
 tb/tb_aes_round_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer for one shared registered round unit
// and an indexed round-key store; whitening is done here, rounds 1..NR by the round unit.
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             key_valid,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [3:0]       key_idx,
    input  logic [127:0]     round_key,
    output logic             rnd_en,
    output logic             rnd_skip_mc,
    output logic [127:0]     rnd_state_in,
    output logic [127:0]     rnd_key,
    input  logic [127:0]     rnd_state_out,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] LAST = 4'(NR);
    state_t       state, state_nx;
    logic [3:0]   rnd, rnd_nx;
    logic [127:0] wst;
    logic         accept, retire;
    assign accept    = state == IDLE && state_nx == RUN;
    assign retire    = state == DONE && out_ready && !abort;
    assign busy      = state != IDLE;
    assign out_data  = rnd_state_out;
    assign rnd_key   = round_key;
    always_comb begin
        state_nx     = state;
        rnd_nx       = rnd;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        rnd_en       = 1'b0;
        rnd_skip_mc  = 1'b0;
        key_idx      = 4'd0;
        rnd_state_in = wst;
        case (state)
            IDLE: begin
                in_ready = key_valid;
                state_nx = in_valid && key_valid ? RUN : IDLE;
                rnd_nx   = in_valid && key_valid ? 4'd1 : rnd;
            end
            RUN: begin
                rnd_en       = !abort;
                key_idx      = rnd;
                rnd_skip_mc  = rnd == LAST;
                rnd_state_in = rnd == 4'd1 ? wst : rnd_state_out;
                state_nx     = rnd == LAST ? DONE : RUN;
                rnd_nx       = rnd == LAST ? rnd : rnd + 4'd1;
            end
            DONE: begin
                out_valid = 1'b1;
                key_idx   = LAST;
                state_nx  = out_ready ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
        // abort overrides every transition, including accept and hand-off
        if (abort) begin
            state_nx = IDLE;
            rnd_nx   = 4'd0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            wst       <= '0;
            blk_count <= '0;
        end else begin
            state <= state_nx;
            rnd   <= rnd_nx;
            if (accept)
                wst <= in_data ^ round_key;
            if (retire)
                blk_count <= blk_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl with an AES-128 key store and registered round unit,
// checking ciphertexts against a whole-block AES reference and the FIPS-197 C.1 vector.
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam int CW = 3;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0, key_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, rnd_en, rnd_skip_mc, busy;
    logic [127:0] in_data = '0, out_data, round_key, rnd_state_in, rnd_key, rnd_state_out;
    logic [3:0] key_idx;
    logic [CW-1:0] blk_count;
    logic [127:0] rk [0:15];
    int tests = 0, fails = 0, cyc = 0, exp_cnt = 0, last_acc = 0;

    aes_round_ctrl #(.NR(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .key_valid(key_valid),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_idx(key_idx), .round_key(round_key), .rnd_en(rnd_en),
        .rnd_skip_mc(rnd_skip_mc), .rnd_state_in(rnd_state_in), .rnd_key(rnd_key),
        .rnd_state_out(rnd_state_out), .busy(busy), .blk_count(blk_count)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction
    // S-box from first principles: inverse is a^254, then the affine map
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r, x;
        r = 8'h01;
        x = a;
        for (int i = 1; i < 8; i++) begin
            x = gm(x, x);
            r = gm(r, x);
        end
        return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
    endfunction
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = last ? {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]} :
                {gm(b[4*c], 2) ^ gm(b[4*c+1], 3) ^ b[4*c+2] ^ b[4*c+3],
                 b[4*c] ^ gm(b[4*c+1], 2) ^ gm(b[4*c+2], 3) ^ b[4*c+3],
                 b[4*c] ^ b[4*c+1] ^ gm(b[4*c+2], 2) ^ gm(b[4*c+3], 3),
                 gm(b[4*c], 3) ^ b[4*c+1] ^ b[4*c+2] ^ gm(b[4*c+3], 2)};
        return o ^ k;
    endfunction
    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
        return s;
    endfunction
    task automatic load_keys(input logic [127:0] key);
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*NR+4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 16; j++) rk[j] = j <= NR ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
    endtask

    assign round_key = rk[key_idx];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rnd_en) rnd_state_out <= aes_round(rnd_state_in, rnd_key, rnd_skip_mc);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    // one block: accept, NR round cycles, DONE held for `hold` extra cycles, hand-off
    task automatic enc(input logic [127:0] pt, input logic [127:0] ct, input int hold, input logic keep, input logic gap);
        in_data = pt;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("in_ready_idle", in_ready, 1);
        tick;
        if (gap) chk("accept_gap", cyc - last_acc, NR + 2);
        last_acc = cyc;
        in_valid = keep;
        for (int c = 1; c <= NR; c++) begin
            chk("rnd_en", rnd_en, 1);
            chk("key_idx", key_idx, c);
            chk("skip_mc", rnd_skip_mc, c == NR);
            chk("in_ready_run", in_ready, 0);
            chk("out_valid_run", out_valid, 0);
            tick;
        end
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, ct);
        chk("key_idx_done", key_idx, NR);
        for (int h = 0; h < hold; h++) begin
            tick;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, ct);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_rnd_en", rnd_en, 0);
        end
        out_ready = 1'b1;
        tick;
        exp_cnt++;
        chk("blk_count", blk_count, exp_cnt % (1 << CW));
        chk("out_valid_idle", out_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [127:0] pt;
        load_keys(128'h000102030405060708090a0b0c0d0e0f);
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rnd_en", rnd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_idx", key_idx, 0);
        chk("rst_blk_count", blk_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_data = C1_PT;
        in_valid = 1'b1;
        repeat (3) begin
            tick;
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_busy", busy, 0);
        end
        key_valid = 1'b1;
        enc(C1_PT, C1_CT, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pt = rnd128();
            enc(pt, aes_ref(pt), 0, i < 2, i > 0);
        end
        pt = rnd128();
        enc(pt, aes_ref(pt), 7, 1'b0, 1'b0);
        repeat (4) begin
            pt = rnd128();
            enc(pt, aes_ref(pt), $urandom_range(0, 3), 1'b0, 1'b0);
        end
        chk("count_wrapped", blk_count, 1);
        // abort in the middle of RUN
        in_data = rnd128();
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        chk("abort_at_rnd5", key_idx, 5);
        abort = 1'b1;
        #1;
        chk("abort_rnd_en", rnd_en, 0);
        tick;
        abort = 1'b0;
        chk("abort_run_idle", busy, 0);
        chk("abort_key_idx", key_idx, 0);
        repeat (NR + 2) begin
            tick;
            chk("abort_no_out", out_valid, 0);
        end
        chk("abort_run_cnt", blk_count, exp_cnt % (1 << CW));
        // abort while DONE with out_ready high
        in_data = rnd128();
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (NR) tick;
        chk("done_before_abort", out_valid, 1);
        out_ready = 1'b1;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        out_ready = 1'b0;
        chk("abort_done_idle", busy, 0);
        chk("abort_done_valid", out_valid, 0);
        chk("abort_done_cnt", blk_count, exp_cnt % (1 << CW));
        pt = rnd128();
        enc(pt, aes_ref(pt), 1, 1'b0, 1'b0);
        // asynchronous reset mid-RUN
        in_data = rnd128();
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        chk("run_before_rst", busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rnd_en", rnd_en, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_key_idx", key_idx, 0);
        chk("arst_blk_count", blk_count, 0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enc(C1_PT, C1_CT, 0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
